// File: rtl/sram_bus_responder_pkg.sv
// Shared definitions for the SRAM bus responder: FSM state codes, default
// timing and the bus-ready naming used by the rest of the system bus.
package sram_bus_responder_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD_ACT   = 3'd1;
  localparam state_t ST_RD_CAP   = 3'd2;
  localparam state_t ST_WR_SETUP = 3'd3;
  localparam state_t ST_WR_PULSE = 3'd4;
  localparam state_t ST_WR_HOLD  = 3'd5;

  localparam int DEF_SRAM_AW      = 18;
  localparam int DEF_RD_WAIT_CYC  = 2;
  localparam int DEF_WR_PULSE_CYC = 2;

  localparam logic BUS_READY = 1'b1;
  localparam logic BUS_STALL = 1'b0;

  localparam logic SRAM_CTL_ON  = 1'b0;
  localparam logic SRAM_CTL_OFF = 1'b1;

  // Wide enough to hold the longest wait without wrapping.
  function automatic int wait_cnt_width(input int rd_cyc, input int wr_cyc);
    int max_cyc;
    max_cyc = (rd_cyc > wr_cyc) ? rd_cyc : wr_cyc;
    return $clog2(max_cyc + 1);
  endfunction

endpackage

// File: rtl/sram_bus_responder_wait_counter.sv
// Saturating down-counter that times SRAM access phases; o_done flags the
// last cycle of the loaded interval.
module sram_bus_responder_wait_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Reload on phase entry, count down and stop at zero.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != CNT_ZERO) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_done = (r_cnt <= CNT_ONE);

endmodule

// File: rtl/sram_bus_responder.sv
// CPU-bus responder that services byte accesses from an external async 16-bit
// SRAM, stalling the CPU through bus_ready while an access is in flight.
module sram_bus_responder
  import sram_bus_responder_pkg::*;
#(
  parameter int                  SRAM_AW      = DEF_SRAM_AW,
  parameter logic [SRAM_AW-16:0] BANK         = {(SRAM_AW-15){1'b0}},
  parameter int                  RD_WAIT_CYC  = DEF_RD_WAIT_CYC,
  parameter int                  WR_PULSE_CYC = DEF_WR_PULSE_CYC
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic [15:0]        bus_addr,
  input  logic [7:0]         bus_wr_data,
  input  logic               bus_rd_req,
  input  logic               bus_wr_en,
  input  logic               bus_cs,
  output logic [7:0]         bus_rd_data,
  output logic               bus_ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int               CNT_W    = wait_cnt_width(RD_WAIT_CYC, WR_PULSE_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_WAIT_CYC);
  localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_PULSE_CYC);

  state_t             r_state;
  logic [7:0]         r_rd_data;
  logic               r_bus_ready;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [15:0]        r_dq_out;
  logic               r_dq_oe;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic               r_ub_n;
  logic               r_lb_n;
  logic               r_lane_hi;

  logic               w_accept;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_done;

  assign w_accept = (r_state == ST_IDLE) && bus_cs && (bus_rd_req || bus_wr_en);

  // Counter reloads on entry to the timed phases: read active and write pulse.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = CNT_ZERO;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && !bus_wr_en) begin
          w_load     = 1'b1;
          w_load_val = RD_LOAD;
        end else begin
          w_load     = 1'b0;
          w_load_val = CNT_ZERO;
        end
      end
      ST_WR_SETUP: begin
        w_load     = 1'b1;
        w_load_val = WR_LOAD;
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = CNT_ZERO;
      end
    endcase
  end

  sram_bus_responder_wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .i_clk      (sys_clk),
    .i_reset_n  (reset_n),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  // Access FSM; every SRAM pin and bus output comes straight from a flop.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rd_data   <= 8'h00;
      r_bus_ready <= BUS_READY;
      r_sram_addr <= {SRAM_AW{1'b0}};
      r_dq_out    <= 16'h0000;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= SRAM_CTL_OFF;
      r_oe_n      <= SRAM_CTL_OFF;
      r_we_n      <= SRAM_CTL_OFF;
      r_ub_n      <= SRAM_CTL_OFF;
      r_lb_n      <= SRAM_CTL_OFF;
      r_lane_hi   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_sram_addr <= {BANK, bus_addr[15:1]};
            r_lane_hi   <= bus_addr[0];
            r_ub_n      <= ~bus_addr[0];
            r_lb_n      <= bus_addr[0];
            r_ce_n      <= SRAM_CTL_ON;
            r_bus_ready <= BUS_STALL;
            // A simultaneous read strobe is dropped in favour of the write.
            if (bus_wr_en) begin
              r_state  <= ST_WR_SETUP;
              r_dq_out <= {bus_wr_data, bus_wr_data};
              r_dq_oe  <= 1'b1;
              r_oe_n   <= SRAM_CTL_OFF;
              r_we_n   <= SRAM_CTL_OFF;
            end else begin
              r_state  <= ST_RD_ACT;
              r_dq_oe  <= 1'b0;
              r_oe_n   <= SRAM_CTL_ON;
              r_we_n   <= SRAM_CTL_OFF;
            end
          end
        end
        ST_RD_ACT: begin
          if (w_done) begin
            r_state <= ST_RD_CAP;
          end
        end
        ST_RD_CAP: begin
          r_rd_data   <= r_lane_hi ? sram_dq_in[15:8] : sram_dq_in[7:0];
          r_bus_ready <= BUS_READY;
          r_ce_n      <= SRAM_CTL_OFF;
          r_oe_n      <= SRAM_CTL_OFF;
          r_ub_n      <= SRAM_CTL_OFF;
          r_lb_n      <= SRAM_CTL_OFF;
          r_state     <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          r_we_n  <= SRAM_CTL_ON;
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (w_done) begin
            r_we_n  <= SRAM_CTL_OFF;
            r_state <= ST_WR_HOLD;
          end
        end
        ST_WR_HOLD: begin
          r_bus_ready <= BUS_READY;
          r_dq_oe     <= 1'b0;
          r_ce_n      <= SRAM_CTL_OFF;
          r_ub_n      <= SRAM_CTL_OFF;
          r_lb_n      <= SRAM_CTL_OFF;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_bus_ready <= BUS_READY;
          r_dq_oe     <= 1'b0;
          r_ce_n      <= SRAM_CTL_OFF;
          r_oe_n      <= SRAM_CTL_OFF;
          r_we_n      <= SRAM_CTL_OFF;
          r_ub_n      <= SRAM_CTL_OFF;
          r_lb_n      <= SRAM_CTL_OFF;
        end
      endcase
    end
  end

  assign bus_rd_data = r_rd_data;
  assign bus_ready   = r_bus_ready;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_ce_n   = r_ce_n;
  assign sram_oe_n   = r_oe_n;
  assign sram_we_n   = r_we_n;
  assign sram_ub_n   = r_ub_n;
  assign sram_lb_n   = r_lb_n;

endmodule
